// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external combinational ALU between two valid/ready ports.
// Define ALU_SEL_CHECK_EN to reject opcodes above 3'b100 without touching the ALU (rsp err=1, data=0).
module alu_share_arbiter #(
    parameter int DW = 4,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic [SW-1:0] req0_sel,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [DW-1:0] rsp0_data,
    output logic          rsp0_err,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    input  logic [SW-1:0] req1_sel,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp1_data,
    output logic          rsp1_err,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [SW-1:0] alu_sel,
    input  logic [DW-1:0] alu_out
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              r_state, w_next;
    logic                r_grant, r_last;
    logic [1:0][DW-1:0]  r_data;
    logic                w_any, w_gnt, w_req_hs, w_rsp_hs, w_bad;
    logic [DW-1:0]       w_a, w_b;
    logic [SW-1:0]       w_sel;

    // On contention the port that was not served last wins; r_last resets to 1 so port 0 goes first.
    assign w_any    = req0_valid | req1_valid;
    assign w_gnt    = (req0_valid & req1_valid) ? ~r_last : req1_valid;
    assign w_req_hs = (r_state == IDLE) & w_any;
    assign w_a      = w_gnt ? req1_a   : req0_a;
    assign w_b      = w_gnt ? req1_b   : req0_b;
    assign w_sel    = w_gnt ? req1_sel : req0_sel;

    assign req0_ready = w_req_hs & ~w_gnt;
    assign req1_ready = w_req_hs & w_gnt;
    assign rsp0_valid = (r_state == RESP) & ~r_grant;
    assign rsp1_valid = (r_state == RESP) & r_grant;
    assign rsp0_data  = r_data[0];
    assign rsp1_data  = r_data[1];
    assign w_rsp_hs   = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

`ifdef ALU_SEL_CHECK_EN
    logic [1:0] r_err;

    assign w_bad    = w_sel > SW'(4);
    assign rsp0_err = r_err[0];
    assign rsp1_err = r_err[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= '0;
        else if (w_req_hs) r_err[w_gnt] <= w_bad;
    end
`else
    assign w_bad    = 1'b0;
    assign rsp0_err = 1'b0;
    assign rsp1_err = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_next = w_bad ? RESP : EXEC;
            EXEC:    w_next = RESP;
            RESP:    if (w_rsp_hs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_data  <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
        end else begin
            r_state <= w_next;
            if (w_req_hs) begin
                r_grant <= w_gnt;
                if (w_bad) begin
                    r_data[w_gnt] <= '0;
                end else begin
                    alu_a   <= w_a;
                    alu_b   <= w_b;
                    alu_sel <= w_sel;
                end
            end
            if (r_state == EXEC) r_data[r_grant] <= alu_out;
            if (w_rsp_hs) r_last <= r_grant;
        end
    end
endmodule
